// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants and types for the 4x4 systolic array blocks.
package systolic_pkg;
    localparam int N          = 4;
    localparam int STREAM_LEN = 2 * N - 1;
    localparam int K_W        = $clog2(STREAM_LEN);
    localparam int DATA_W     = 16;
    typedef logic signed [DATA_W-1:0] tile_t [N][N];
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} feeder_state_t;
endpackage

// File: rtl/systolic_feeder_skew_select.sv
// skew_select: picks the zero-filled diagonal element of each tile row for step k.
module skew_select
    import systolic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] tile [N][N],
    input  logic        [K_W-1:0]   k,
    output logic signed [WIDTH-1:0] lane [N]
);
    always_comb begin
        for (int r = 0; r < N; r++) begin
            lane[r] = '0;
            for (int c = 0; c < N; c++)
                if (int'(k) - r == c) lane[r] = tile[r][c];
        end
    end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: captures a 4x4 activation tile and streams it as diagonally skewed rows.
// Define SYSTOLIC_FEEDER_DRAIN_EN to append an N-cycle drain phase after each tile.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] tile_in [N][N],
    input  logic                    tile_valid,
    output logic                    tile_ready,
    output logic signed [WIDTH-1:0] out_left [N],
    output logic                    out_valid,
    output logic                    busy,
    output logic                    tile_done
);
    feeder_state_t state, state_d;
    logic [K_W-1:0] k, k_d;
    logic signed [WIDTH-1:0] tile   [N][N];
    logic signed [WIDTH-1:0] tile_d [N][N];
    logic signed [WIDTH-1:0] lane   [N];
    logic accept, last, done_d;

    assign last   = k == K_W'(STREAM_LEN - 1);
    assign accept = tile_valid && tile_ready;
    assign busy   = state != IDLE;
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
    assign tile_ready = rst && (state == IDLE || (state == DRAIN && k == K_W'(N - 1)));
`else
    assign tile_ready = rst && (state == IDLE || (state == STREAM && last));
`endif

    always_comb begin
        state_d = IDLE;
        k_d     = '0;
        if (accept)
            state_d = STREAM;
        else if (state == STREAM && !last) begin
            state_d = STREAM;
            k_d     = k + K_W'(1);
        end
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
        else if (state == STREAM)
            state_d = DRAIN;
        else if (state == DRAIN && k != K_W'(N - 1)) begin
            state_d = DRAIN;
            k_d     = k + K_W'(1);
        end
        done_d = state_d == DRAIN && k_d == K_W'(N - 1);
`else
        done_d = state_d == STREAM && k_d == K_W'(STREAM_LEN - 1);
`endif
    end

    // Lanes are computed from next-cycle tile and step so the outputs can be registered.
    always_comb begin
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                tile_d[r][c] = accept ? tile_in[r][c] : tile[r][c];
    end

    skew_select #(.WIDTH(WIDTH)) u_skew (
        .tile (tile_d),
        .k    (k_d),
        .lane (lane)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            k         <= '0;
            out_valid <= 1'b0;
            tile_done <= 1'b0;
            for (int r = 0; r < N; r++) begin
                out_left[r] <= '0;
                for (int c = 0; c < N; c++) tile[r][c] <= '0;
            end
        end else begin
            state     <= state_d;
            k         <= k_d;
            out_valid <= state_d == STREAM;
            tile_done <= done_d;
            for (int r = 0; r < N; r++) begin
                out_left[r] <= state_d == STREAM ? lane[r] : '0;
                for (int c = 0; c < N; c++) tile[r][c] <= tile_d[r][c];
            end
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: table vectors, corner sequences and random tiles against a timeline model.
module tb_systolic_feeder;
    import systolic_pkg::*;
    localparam int W   = 16;
    localparam int LEN = 2 * N - 1;
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
    localparam int TAIL = N;
`else
    localparam int TAIL = 0;
`endif

    typedef struct {
        bit tv;
        int l [N];
        bit v, d, r, b;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0, tile_valid = 1'b0;
    logic signed [W-1:0] tile_in [N][N];
    logic signed [W-1:0] out_left [N];
    logic tile_ready, out_valid, busy, tile_done;

    int checks = 0, errors = 0, cyc = 0;
    int acc_cyc = -1000;
    logic signed [W-1:0] acc_tile [N][N];
    vec_t tbl [12];

    systolic_feeder #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .tile_in    (tile_in),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .out_left   (out_left),
        .out_valid  (out_valid),
        .busy       (busy),
        .tile_done  (tile_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_io(input string name, input int l0, l1, l2, l3, input bit v, d, r, b);
        chk({name, "_lane0"}, out_left[0], l0);
        chk({name, "_lane1"}, out_left[1], l1);
        chk({name, "_lane2"}, out_left[2], l2);
        chk({name, "_lane3"}, out_left[3], l3);
        chk({name, "_valid"}, out_valid, v);
        chk({name, "_done"}, tile_done, d);
        chk({name, "_ready"}, tile_ready, r);
        chk({name, "_busy"}, busy, b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Timeline model: a tile accepted during cycle a occupies cycles a+1 .. a+LEN+TAIL.
    function automatic bit model_active();
        return cyc > acc_cyc && cyc <= acc_cyc + LEN + TAIL;
    endfunction

    function automatic bit model_ready();
        return !model_active() || cyc == acc_cyc + LEN + TAIL;
    endfunction

    task automatic check_model();
        int k;
        bit act;
        longint e;
        act = model_active();
        k = cyc - acc_cyc - 1;
        for (int r = 0; r < N; r++) begin
            e = 0;
            if (act && k - r >= 0 && k - r < N) e = acc_tile[r][k - r];
            chk($sformatf("lane%0d", r), out_left[r], e);
        end
        chk("valid", out_valid, act && k < LEN);
        chk("done", tile_done, act && cyc == acc_cyc + LEN + TAIL);
        chk("ready", tile_ready, model_ready());
        chk("busy", busy, act);
    endtask

    task automatic step(input bit tv);
        bit acc;
        tile_valid = tv;
        acc = tv && model_ready();
        tick();
        if (acc) begin
            acc_cyc = cyc - 1;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) acc_tile[r][c] = tile_in[r][c];
        end
        check_model();
    endtask

    task automatic load_ramp();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) tile_in[r][c] = W'(10 * r + c + 1);
    endtask

    task automatic load_const(input int v);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) tile_in[r][c] = W'(v);
    endtask

    task automatic load_rand();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) tile_in[r][c] = W'($urandom);
    endtask

    task automatic set(input int i, input bit tv, input int l0, l1, l2, l3);
        tbl[i].tv = tv;
        tbl[i].l  = '{l0, l1, l2, l3};
        tbl[i].v  = i <= LEN - 1;
        tbl[i].d  = i == LEN + TAIL - 1;
        tbl[i].r  = i >= LEN + TAIL - 1;
        tbl[i].b  = i <= LEN + TAIL - 1;
    endtask

    initial begin
        bit pend;
        int a0;
        set(0, 1, 1, 0, 0, 0);
        set(1, 0, 2, 11, 0, 0);
        set(2, 0, 3, 12, 21, 0);
        set(3, 0, 4, 13, 22, 31);
        set(4, 0, 0, 14, 23, 32);
        set(5, 0, 0, 0, 24, 33);
        set(6, 0, 0, 0, 0, 34);
        for (int i = 7; i < 12; i++) set(i, 0, 0, 0, 0, 0);
        load_const(0);

        #2;
        chk_io("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        tile_valid = 1'b1;
        tick();
        tick();
        chk_io("reset_held", 0, 0, 0, 0, 0, 0, 0, 0);
        tile_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step(0);

        load_ramp();
        for (int i = 0; i < 12; i++) begin
            tile_valid = tbl[i].tv;
            tick();
            if (i == 0) load_const(99);
            chk_io($sformatf("tbl%0d", i), tbl[i].l[0], tbl[i].l[1], tbl[i].l[2], tbl[i].l[3],
                   tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].b);
        end

        load_ramp();
        a0 = cyc;
        step(1);
        load_const(-5);
        for (int i = 0; i < LEN + TAIL; i++) step(1);
        chk("b2b_cycle", cyc, a0 + LEN + TAIL + 1);
        chk("b2b_lane0", out_left[0], -5);
        chk("b2b_valid", out_valid, 1);
        tile_valid = 1'b0;
        for (int i = 0; i < LEN + TAIL + 1; i++) step(0);

        load_rand();
        step(1);
        for (int i = 0; i < 3; i++) step(0);
        chk("bp_ready", tile_ready, 0);
        load_rand();
        step(1);
        while (!model_ready()) step(1);
        step(1);
        for (int i = 0; i < LEN + TAIL + 1; i++) step(0);

        load_rand();
        step(1);
        for (int i = 0; i < 3; i++) step(0);
        rst = 1'b0;
        #1;
        chk_io("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_io("rst_mid_held", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        acc_cyc = -1000;
        for (int i = 0; i < LEN + TAIL + 1; i++) step(0);
        load_rand();
        step(1);
        for (int i = 0; i < LEN + TAIL + 1; i++) step(0);

        pend = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!pend && $urandom_range(0, 3) == 0) begin
                load_rand();
                pend = 1'b1;
            end
            if (pend && model_ready()) begin
                step(1);
                pend = 1'b0;
            end else begin
                step(pend);
            end
        end
        tile_valid = 1'b0;
        for (int i = 0; i < LEN + TAIL + 1; i++) step(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
